// File: rtl/gsensor_spi_responder_if.sv
// SPI bus between the accelerometer controller (master) and the G-sensor
// responder model (slave); spi_sdo_oe tells the master when spi_sdo is driven.
interface gsensor_spi_responder_if;
  logic spi_csn;
  logic spi_clk;
  logic spi_sdi;
  logic spi_sdo;
  logic spi_sdo_oe;

  modport master (
    output spi_csn, spi_clk, spi_sdi,
    input  spi_sdo, spi_sdo_oe
  );

  modport slave (
    input  spi_csn, spi_clk, spi_sdi,
    output spi_sdo, spi_sdo_oe
  );
endinterface

// File: rtl/gsensor_spi_responder.sv
// Register-level model of the board accelerometer: oversampled mode-3 SPI slave
// over a 64x8 register file with host-fed X/Y/Z samples and a data-ready interrupt.
module gsensor_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  gsensor_spi_responder_if.slave        spi,
  input  logic [15:0]                   sample_x,
  input  logic [15:0]                   sample_y,
  input  logic [15:0]                   sample_z,
  input  logic                          sample_valid,
  output logic                          int1
);

  localparam logic [5:0] INT_ENABLE = 6'h2E;
  localparam logic [5:0] INT_SOURCE = 6'h30;
  localparam logic [5:0] DATAX0     = 6'h32;
  localparam logic [5:0] DATAZ1     = 6'h37;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  logic [SYNC_STAGES-1:0] csn_sync, clk_sync, sdi_sync;
  logic                   csn_d, clk_d;
  logic                   csn_s, clk_s, sdi_s;
  logic                   csn_fall, csn_rise, sclk_rise, sclk_fall;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [6:0]  shift_out;
  logic        rw, mb;
  logic [5:0]  addr;
  logic        sdo, oe;
  logic        pend_valid;
  logic [15:0] pend_x, pend_y, pend_z;
  logic [7:0]  regs [64];

  logic [5:0]  cmd_addr, next_addr;
  logic [7:0]  cmd_byte, next_byte, in_byte;
  logic [15:0] new_x, new_y, new_z;

  // Sync chains reset to the bus idle levels so release of reset is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn_sync <= '1;
      clk_sync <= '1;
      sdi_sync <= '0;
      csn_d    <= 1'b1;
      clk_d    <= 1'b1;
    end else begin
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi.spi_csn};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi.spi_clk};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi.spi_sdi};
      csn_d    <= csn_sync[SYNC_STAGES-1];
      clk_d    <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign csn_fall  = csn_d & ~csn_s;
  assign csn_rise  = ~csn_d & csn_s;
  assign sclk_rise = ~clk_d & clk_s;
  assign sclk_fall = clk_d & ~clk_s;

  function automatic logic [7:0] rd_reg(input logic [5:0] a);
    return (a == 6'h00) ? DEVID : regs[a];
  endfunction

  function automatic logic read_only(input logic [5:0] a);
    return (a == 6'h00) || (a == INT_SOURCE) || (a >= DATAX0 && a <= DATAZ1);
  endfunction

  // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
  always_comb begin
    cmd_addr  = {shift_in[4:0], sdi_s};
    cmd_byte  = rd_reg(cmd_addr);
    next_addr = mb ? addr + 6'd1 : addr;
    next_byte = rd_reg(next_addr);
    in_byte   = {shift_in, sdi_s};
    new_x     = sample_valid ? sample_x : pend_x;
    new_y     = sample_valid ? sample_y : pend_y;
    new_z     = sample_valid ? sample_z : pend_z;
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in
  // this block intentionally override earlier ones (sample set beats 0x37 read-clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      rw         <= 1'b0;
      mb         <= 1'b0;
      addr       <= '0;
      sdo        <= 1'b0;
      oe         <= 1'b0;
      int1       <= 1'b0;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      // NOTE: the register file is small and must read as zero after reset, so it is reset.
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else begin
      int1 <= regs[INT_SOURCE][7] & regs[INT_ENABLE][7];

      if (csn_rise) begin
        state   <= ST_IDLE;
        oe      <= 1'b0;
        sdo     <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: if (csn_fall) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
            oe      <= 1'b1;
            sdo     <= 1'b0;
          end
          ST_CMD: if (sclk_rise) begin
            shift_in <= in_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw    <= shift_in[6];
              mb    <= shift_in[5];
              addr  <= cmd_addr;
              state <= ST_DATA;
              if (shift_in[6]) begin
                shift_out <= cmd_byte[6:0];
                sdo       <= cmd_byte[7];
              end else begin
                sdo <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              shift_in <= in_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= next_addr;
                if (rw) begin
                  shift_out <= next_byte[6:0];
                  sdo       <= next_byte[7];
                end else if (!read_only(addr)) begin
                  regs[addr] <= in_byte;
                end
              end
            end else if (sclk_fall && rw && bit_cnt != 3'd0) begin
              // The byte MSB is already on the pin; falls 2..8 present the rest.
              sdo       <= shift_out[6];
              shift_out <= {shift_out[5:0], 1'b0};
              if (bit_cnt == 3'd7 && addr == DATAZ1) regs[INT_SOURCE][7] <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Samples arriving mid-transaction wait until the bus is released.
      if (state != ST_IDLE && sample_valid) begin
        pend_valid <= 1'b1;
        pend_x     <= sample_x;
        pend_y     <= sample_y;
        pend_z     <= sample_z;
      end else if (state == ST_IDLE && (sample_valid || pend_valid)) begin
        pend_valid          <= 1'b0;
        regs[6'h32]         <= new_x[7:0];
        regs[6'h33]         <= new_x[15:8];
        regs[6'h34]         <= new_y[7:0];
        regs[6'h35]         <= new_y[15:8];
        regs[6'h36]         <= new_z[7:0];
        regs[6'h37]         <= new_z[15:8];
        regs[INT_SOURCE][7] <= 1'b1;
      end
    end
  end

  assign spi.spi_sdo    = sdo;
  assign spi.spi_sdo_oe = oe;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for gsensor_spi_responder: drives mode-3 SPI transactions and
// compares returned bytes, output enable and int1 with hand-computed values.
module tb_gsensor_spi_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        sample_valid = 1'b0;
  logic        int1;
  int          total = 0;
  int          bad = 0;

  gsensor_spi_responder_if bus ();

  gsensor_spi_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi          (bus.slave),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .int1         (int1)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start();
    bus.spi_csn = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    bus.spi_csn = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Shifts the top n bits of tx out MSB first, capturing spi_sdo just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_clk = 1'b0;
      bus.spi_sdi = tx[i];
      wait_clk(HALF);
      rx[i] = bus.spi_sdo;
      bus.spi_clk = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rx;
    spi_start();
    spi_bits({2'b00, a[5:0]}, 8, rx);
    spi_bits(d, 8, rx);
    spi_end();
  endtask

  task automatic spi_read1(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] rx;
    spi_start();
    spi_bits({2'b10, a[5:0]}, 8, rx);
    spi_bits(8'h00, 8, d);
    spi_end();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.spi_sdo_oe !== 1'b0 || bus.spi_sdo !== 1'b0 || int1 !== 1'b0) begin
      $display("FAIL reset_outputs got oe=%b sdo=%b int1=%b exp all 0", bus.spi_sdo_oe, bus.spi_sdo, int1);
      bad++;
    end
  endtask

  task automatic test_devid();
    logic [7:0] rx;
    spi_start();
    total++;
    if (bus.spi_sdo_oe !== 1'b1) begin
      $display("FAIL oe_selected got=%b exp=1", bus.spi_sdo_oe); bad++;
    end
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_end();
    total++;
    if (rx !== 8'hE5) begin $display("FAIL devid got=%h exp=e5", rx); bad++; end
    total++;
    if (bus.spi_sdo_oe !== 1'b0) begin
      $display("FAIL oe_after_csn got=%b exp=0", bus.spi_sdo_oe); bad++;
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rx;
    spi_write(8'h2D, 8'h08);
    spi_read1(8'h2D, rx);
    total++;
    if (rx !== 8'h08) begin $display("FAIL rw_2d got=%h exp=08", rx); bad++; end
    spi_write(8'h32, 8'hFF);
    spi_read1(8'h32, rx);
    total++;
    if (rx !== 8'h00) begin $display("FAIL ro_32 got=%h exp=00", rx); bad++; end
  endtask

  task automatic test_burst_coherent();
    logic [7:0] rx;
    logic [7:0] exp1 [6] = '{8'h23, 8'h01, 8'hDC, 8'hFE, 8'h40, 8'h00};
    pulse_sample(16'h0123, 16'hFEDC, 16'h0040);
    wait_clk(2);
    spi_start();
    spi_bits(8'hF2, 8, rx);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) pulse_sample(16'h7FFF, 16'hFEDC, 16'h0040);
      spi_bits(8'h00, 8, rx);
      total++;
      if (rx !== exp1[i]) begin $display("FAIL burst1_byte%0d got=%h exp=%h", i, rx, exp1[i]); bad++; end
    end
    spi_end();
  endtask

  task automatic test_int_and_wrap();
    logic [7:0] rx;
    logic [7:0] exp2 [6] = '{8'hFF, 8'h7F, 8'hDC, 8'hFE, 8'h40, 8'h00};
    // Full burst returns the pending sample and clears the data-ready flag.
    spi_start();
    spi_bits(8'hF2, 8, rx);
    for (int i = 0; i < 6; i++) begin
      spi_bits(8'h00, 8, rx);
      total++;
      if (rx !== exp2[i]) begin $display("FAIL burst2_byte%0d got=%h exp=%h", i, rx, exp2[i]); bad++; end
    end
    spi_end();
    spi_write(8'h2E, 8'h80);
    wait_clk(2);
    total++;
    if (int1 !== 1'b0) begin $display("FAIL int1_cleared got=%b exp=0", int1); bad++; end
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    total++;
    if (int1 !== 1'b0) begin $display("FAIL int1_latency got=%b exp=0", int1); bad++; end
    wait_clk(1);
    total++;
    if (int1 !== 1'b1) begin $display("FAIL int1_set got=%b exp=1", int1); bad++; end
    spi_read1(8'h30, rx);
    total++;
    if (rx !== 8'h80) begin $display("FAIL int_source got=%h exp=80", rx); bad++; end
    spi_start();
    spi_bits(8'hF2, 8, rx);
    for (int i = 0; i < 6; i++) spi_bits(8'h00, 8, rx);
    spi_end();
    total++;
    if (int1 !== 1'b0) begin $display("FAIL int1_after_0x37 got=%b exp=0", int1); bad++; end
    spi_start();
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'h00, 8, rx);
    total++;
    if (rx !== 8'h00) begin $display("FAIL wrap_3f got=%h exp=00", rx); bad++; end
    spi_bits(8'h00, 8, rx);
    total++;
    if (rx !== 8'hE5) begin $display("FAIL wrap_00 got=%h exp=e5", rx); bad++; end
    spi_end();
  endtask

  task automatic test_abort_write();
    logic [7:0] rx;
    spi_start();
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h55, 5, rx);
    spi_end();
    spi_read1(8'h2D, rx);
    total++;
    if (rx !== 8'h08) begin $display("FAIL abort_write got=%h exp=08", rx); bad++; end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    spi_start();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 3, rx);
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.spi_sdo_oe !== 1'b0) begin $display("FAIL oe_async_reset got=%b exp=0", bus.spi_sdo_oe); bad++; end
    bus.spi_csn = 1'b1;
    bus.spi_clk = 1'b1;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    spi_read1(8'h00, rx);
    total++;
    if (rx !== 8'hE5) begin $display("FAIL devid_after_reset got=%h exp=e5", rx); bad++; end
    spi_read1(8'h2D, rx);
    total++;
    if (rx !== 8'h00) begin $display("FAIL reg_after_reset got=%h exp=00", rx); bad++; end
  endtask

  initial begin
    bus.spi_csn = 1'b1;
    bus.spi_clk = 1'b1;
    bus.spi_sdi = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    test_reset();
    test_devid();
    test_write_read();
    test_burst_coherent();
    test_int_and_wrap();
    test_abort_write();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gsensor_spi_responder.md
# gsensor_spi_responder

Synthesizable SPI responder that models the board accelerometer's register-level interface. It lets the SPI accelerometer controller be exercised in simulation, or driven on-chip in loopback, without the physical G-sensor. It samples the controller's SPI_CSN/SPI_CLK/SPI_SDI lines in the system clock domain, decodes read/write transactions against a 64×8 register file, returns data on SDO, and presents host-supplied X/Y/Z samples at the data registers.

## Interface
Parameters:
- DEVID, 8'hE5, value returned at register 0x00 (read-only)
- SYNC_STAGES, 2, synchronizer depth on spi_csn/spi_clk/spi_sdi (≥2)

Ports:
- clk  in  1  system clock; must be ≥ 8× spi_clk frequency
- reset_n  in  1  asynchronous, active-low reset
- spi_csn  in  1  chip select, active low
- spi_clk  in  1  SPI clock, mode 3 (idles high)
- spi_sdi  in  1  controller-to-responder data, MSB first
- spi_sdo  out  1  responder-to-controller data
- spi_sdo_oe  out  1  output enable for spi_sdo; 1 only while selected
- sample_x, sample_y, sample_z  in  16 each  new accelerometer sample, two's complement
- sample_valid  in  1  one-cycle strobe; sample_* valid this cycle
- int1  out  1  data-ready interrupt, = INT_SOURCE[7] & INT_ENABLE[7]

## Operation
- Input conditioning: each SPI input passes through SYNC_STAGES flops. Edges are detected on the synchronized values:
  - csn_fall / csn_rise on spi_csn
  - sclk_rise / sclk_fall on spi_clk
- FSM states:
  - IDLE: csn_fall → CMD, bit counter = 0, spi_sdo_oe = 1.
  - CMD: shift spi_sdi on each sclk_rise. After 8 bits, latch R/W = bit7, MB = bit6, addr = bits[5:0], then go to DATA.
  - DATA: byte loop of 8 bits each.
  - csn_rise in any state → IDLE, spi_sdo_oe = 0, partial byte discarded.
- Read (R/W = 1):
  - At CMD→DATA, load shift-out register with reg[addr]; drive its MSB on spi_sdo immediately.
  - On each sclk_fall, shift out the next bit.
  - After the 8th bit, advance addr and load the next byte.
  - Unselected or write phase: spi_sdo = 0.
- Write (R/W = 0): the byte is committed to reg[addr] on the 8th sclk_rise, then addr advances.
- Addr advance: if MB = 1, addr + 1 with wrap 0x3F → 0x00. If MB = 0, addr is unchanged.
- Read-only addresses: 0x00 (DEVID), 0x30 (INT_SOURCE), 0x32–0x37 (DATAX0..DATAZ1, little-endian X, Y, Z). Writes to these are ignored but still advance addr. All other addresses are plain R/W storage.
- INT_ENABLE is 0x2E.
- Sample update:
  - sample_valid while IDLE: write sample_* into 0x32–0x37 and set INT_SOURCE[7].
  - sample_valid during a transaction: store in a one-deep pending slot (newest wins). Apply it on the cycle after csn_rise, so multi-byte reads are coherent.
- Reading 0x37 clears INT_SOURCE[7] at the byte's last sclk_fall. If a sample is applied in the same cycle, the set wins.
- Reset (asynchronous): FSM → IDLE; all registers 0 except DEVID; pending slot empty; spi_sdo = 0, spi_sdo_oe = 0, int1 = 0. An assertion mid-transaction aborts it with no commit.

## Timing
- Synchronizer plus edge detect gives SYNC_STAGES+1 clk cycles from a pin edge to the action.
- First read bit is valid on spi_sdo SYNC_STAGES+1 cycles after the sclk_rise of command bit 0 (the 8th command bit). This must precede the next spi_clk fall.
- Subsequent bits change SYNC_STAGES+1 cycles after each spi_clk fall and are stable at the following rise.
- spi_sdo_oe rises SYNC_STAGES+1 cycles after the spi_csn fall and drops SYNC_STAGES+1 cycles after the spi_csn rise.
- Write commit: register updated on the cycle following the detected 8th sclk_rise.
- int1 is registered: one cycle after INT_SOURCE or INT_ENABLE changes.
- spi_clk edges must be ≥ 4 clk cycles apart. Behaviour is undefined otherwise.

## Test plan
- Read 0x00 (command 0x80, then 8 clocks) → returns 0xE5; spi_sdo_oe low before and after CSN.
- Write 0x2D = 0x08, then read 0x2D → 0x08. Write 0x32 = 0xFF → next read of 0x32 is unchanged.
- sample_x = 0x0123, y = 0xFEDC, z = 0x0040 while idle, then burst-read 0x32 with MB (command 0xF2, 6 bytes) → 23 01 DC FE 40 00.
- During that burst, strobe sample_x = 0x7FFF mid-transfer → burst still returns old data. A second burst returns FF 7F.
- INT_ENABLE = 0x80, then sample_valid → int1 = 1 one cycle after INT_SOURCE[7] sets. Burst read through 0x37 → int1 = 0. MB read from 0x3F wraps to 0x00 (second byte 0xE5).
- Drop CSN after 5 bits of a write data byte → target register unchanged. Assert reset_n mid-read → spi_sdo_oe = 0 immediately; next transaction decodes normally.
